approx_adder_error_monitor: RTL
===============================

# approx_adder_error_monitor

Sequential stimulus-and-check harness that sits at the other end of the interface of a combinational approximate adder: it drives every operand pair onto the adder's flattened inputs and reads back the adder's result. For each pair it computes the absolute error against the exact sum and accumulates worst-case, count and total error. It reports pass/fail against the error threshold the approximate circuit was synthesised for. It is used on silicon/FPGA builds to confirm that a generated approximate adder honours its error bound.

## Interface
- `IN_W`, default 4: operand width; the DUT has 2*IN_W inputs.
- `OUT_W`, default IN_W+1: DUT result width.
- `ET`, default 14: error threshold; pass requires max error <= ET.
- `N_VEC`, fixed at 2**(2*IN_W): number of vectors per sweep (localparam).

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: begin a sweep; sampled only in IDLE.
- `dut_in`, out, 2*IN_W: drives DUT in0..in(2*IN_W-1); bit k is in(k); [IN_W-1:0] = operand a, upper half = operand b, LSB first.
- `dut_out`, in, OUT_W: DUT out0..out(OUT_W-1); bit k is out(k).
- `busy`, out, 1: sweep or drain in progress.
- `done`, out, 1: one-cycle pulse when results are final.
- `pass`, out, 1: max_err <= ET; valid when done has pulsed.
- `max_err`, out, OUT_W: worst absolute error.
- `worst_vec`, out, 2*IN_W: first vector, in sweep order, reaching max_err.
- `err_count`, out, 2*IN_W+1: number of vectors with nonzero error.
- `sum_err`, out, 2*IN_W+OUT_W: sum of absolute errors.

## Operation
- FSM states: IDLE, SWEEP, DRAIN, DONE.
  - IDLE + start -> SWEEP. Clear the accumulators and load vector counter v=0.
  - SWEEP: dut_in = v (registered); v increments each cycle. After v = N_VEC-1 is presented -> DRAIN.
  - DRAIN: one cycle that absorbs the last pipelined compare -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- start is ignored in SWEEP, DRAIN and DONE. Holding start high through DONE starts a new sweep on the first IDLE cycle.
- Compare pipeline, stage 1: in the cycle vector v is on dut_in, register dut_out, the exact sum a+b (IN_W+1 bits, zero-extended to OUT_W) and v.
- Compare pipeline, stage 2: err = |captured_out - exact|, an unsigned OUT_W-bit magnitude.
  - Update `sum_err += err`.
  - If err != 0, `err_count += 1`.
  - If err > max_err (strictly greater), update max_err and worst_vec. Ties keep the earlier vector.
- Widths are sized so that no accumulator wraps for the full sweep.
- `pass` is registered with done, and results hold until the next accepted start.
- Reset values: dut_in=0, busy=0, done=0, pass=0, max_err=0, worst_vec=0, err_count=0, sum_err=0; FSM=IDLE.
- Reset mid-sweep aborts the sweep immediately. All outputs take their reset values, and a new start is required.
- The DUT is purely combinational, so dut_out must settle within one cycle of dut_in changing.

## Timing
- start seen at edge t:
  - busy=1 from cycle t+1.
  - Vector v is on dut_in during cycle t+1+v.
  - DRAIN occupies cycle t+1+N_VEC.
  - done=1 and busy=0 during cycle t+2+N_VEC.
- Total sweep latency is N_VEC+2 cycles, or 258 for IN_W=4.
- Accumulators reflect vector v two edges after v is presented. Results are final at the edge that raises done.

## Structure
- Shared package `approx_chk_pkg`:
  - FSM state enum.
  - Width helper constants: OUT_W, counter width 2*IN_W, accumulator widths.
  - The default ET.
- One natural sub-module, `abs_err_acc`: the stage-2 error magnitude and accumulator logic (max/argmax, count, sum) with a clear input. The top holds the FSM, vector counter and stage-1 registers.

## Test plan
- Exact-adder stub (dut_out = a+b), start pulse -> done at cycle t+258; max_err=0, err_count=0, sum_err=0, worst_vec=0, pass=1.
- Constant-zero stub (dut_out=0) -> max_err=30, worst_vec=8'hFF, err_count=255, sum_err=3840, pass=0.
- Off-by-one stub (dut_out = a+b+1) -> max_err=1, worst_vec=8'h00 (tie keeps the first), err_count=256, sum_err=256, pass=1.
- ET boundary stub (dut_out = a+b except vector 8'h37 returns a+b+14, then repeat with +15) -> first run max_err=14, worst_vec=8'h37, pass=1; second run max_err=15, pass=0.
- Deassert rst_n at cycle t+100 mid-sweep -> all outputs at reset values next cycle. A subsequent start yields a full 258-cycle sweep with correct results; start pulses during busy change nothing.
- Back-to-back: start held high -> second sweep begins the cycle after done, and accumulators are cleared (the exact stub again gives all zeros).

Source files
------------

// File: rtl/approx_adder_error_monitor_pkg.sv
// Shared types and width helpers for the approximate-adder error monitor.
// Holds the FSM state enum, default parameters and accumulator widths.
package approx_chk_pkg;

  localparam int IN_W_DEF = 4;
  localparam int ET_DEF   = 14;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN,
    DONE
  } state_e;

  // Exact sum of two in_w operands needs one carry bit.
  function automatic int out_w(input int in_w);
    return in_w + 1;
  endfunction

  // Vector counter / operand-pair width.
  function automatic int vec_w(input int in_w);
    return 2 * in_w;
  endfunction

  // err_count must hold N_VEC itself.
  function automatic int cnt_w(input int in_w);
    return 2 * in_w + 1;
  endfunction

  // sum_err must hold N_VEC * (2**out_w - 1).
  function automatic int sum_w(input int in_w, input int ow);
    return 2 * in_w + ow;
  endfunction

endpackage

// File: rtl/approx_adder_error_monitor_if.sv
// Bus between the error monitor, its operator and the adder under test.
// master: monitor side (drives dut_in + results); slave: environment side.
interface approx_adder_error_monitor_if
  import approx_chk_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = out_w(IN_W),
  localparam int VW   = vec_w(IN_W),
  localparam int CW   = cnt_w(IN_W),
  localparam int SW   = sum_w(IN_W, OUT_W)
);

  logic             start;
  logic [VW-1:0]    dut_in;
  logic [OUT_W-1:0] dut_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [OUT_W-1:0] max_err;
  logic [VW-1:0]    worst_vec;
  logic [CW-1:0]    err_count;
  logic [SW-1:0]    sum_err;

  modport master (
    input  start,
    input  dut_out,
    output dut_in,
    output busy,
    output done,
    output pass,
    output max_err,
    output worst_vec,
    output err_count,
    output sum_err
  );

  modport slave (
    output start,
    output dut_out,
    input  dut_in,
    input  busy,
    input  done,
    input  pass,
    input  max_err,
    input  worst_vec,
    input  err_count,
    input  sum_err
  );

endinterface

// File: rtl/approx_adder_error_monitor_abs_err_acc.sv
// Stage 2: |captured - exact| plus max/argmax, nonzero count and sum.
// Ports: clear_i zeroes all, valid_i qualifies a compare; max_nxt_o = next max.
module abs_err_acc
  import approx_chk_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = out_w(IN_W),
  localparam int VW   = vec_w(IN_W),
  localparam int CW   = cnt_w(IN_W),
  localparam int SW   = sum_w(IN_W, OUT_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             valid_i,
  input  logic [OUT_W-1:0] out_i,
  input  logic [OUT_W-1:0] exact_i,
  input  logic [VW-1:0]    vec_i,
  output logic [OUT_W-1:0] max_err_o,
  output logic [VW-1:0]    worst_vec_o,
  output logic [CW-1:0]    err_count_o,
  output logic [SW-1:0]    sum_err_o,
  output logic [OUT_W-1:0] max_nxt_o
);

  logic [OUT_W-1:0] err;
  logic [OUT_W-1:0] max_q, max_d;
  logic [VW-1:0]    worst_q, worst_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    sum_q, sum_d;

  assign err = (out_i >= exact_i) ? out_i - exact_i
                                  : exact_i - out_i;

  always_comb begin
    max_d   = max_q;
    worst_d = worst_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    if (clear_i) begin
      max_d   = '0;
      worst_d = '0;
      cnt_d   = '0;
      sum_d   = '0;
    end else if (valid_i) begin
      sum_d = sum_q + SW'(err);
      if (err != '0) cnt_d = cnt_q + CW'(1);
      // Strict compare: ties keep the earlier vector.
      if (err > max_q) begin
        max_d   = err;
        worst_d = vec_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q   <= '0;
      worst_q <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
    end else begin
      max_q   <= max_d;
      worst_q <= worst_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
    end
  end

  assign max_err_o   = max_q;
  assign worst_vec_o = worst_q;
  assign err_count_o = cnt_q;
  assign sum_err_o   = sum_q;
  assign max_nxt_o   = max_d;

endmodule

// File: rtl/approx_adder_error_monitor.sv
// Exhaustive sweep harness for a combinational approximate adder.
// Ports: clk, rst_n (async low), bus (master: start in, dut_in/results out).
module approx_adder_error_monitor
  import approx_chk_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = out_w(IN_W),
  parameter int ET    = ET_DEF,
  localparam int VW   = vec_w(IN_W),
  localparam int N_VEC = 2 ** VW
) (
  input logic clk,
  input logic rst_n,
  approx_adder_error_monitor_if.master bus
);

  localparam logic [VW-1:0] LAST = VW'(N_VEC - 1);

  state_e state_q, state_d;

  logic [VW-1:0]    v_q, v_d;
  logic             pass_q, pass_d;
  logic             clr;
  logic [OUT_W-1:0] exact;
  logic [OUT_W-1:0] max_nxt;

  logic             s1_vld_q;
  logic [OUT_W-1:0] s1_out_q;
  logic [OUT_W-1:0] s1_exact_q;
  logic [VW-1:0]    s1_vec_q;

  assign exact = OUT_W'(v_q[IN_W-1:0])
               + OUT_W'(v_q[VW-1:IN_W]);

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    pass_d  = pass_q;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SWEEP;
          v_d     = '0;
          pass_d  = 1'b0;
          clr     = 1'b1;
        end
      end
      SWEEP: begin
        if (v_q == LAST) state_d = DRAIN;
        else             v_d     = v_q + VW'(1);
      end
      DRAIN: begin
        // Last compare lands this edge; judge on its result.
        state_d = DONE;
        pass_d  = (int'(max_nxt) <= ET);
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      v_q     <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      pass_q  <= pass_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_out_q   <= '0;
      s1_exact_q <= '0;
      s1_vec_q   <= '0;
    end else begin
      s1_vld_q   <= (state_q == SWEEP);
      s1_out_q   <= bus.dut_out;
      s1_exact_q <= exact;
      s1_vec_q   <= v_q;
    end
  end

  abs_err_acc #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_acc (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (clr),
    .valid_i     (s1_vld_q),
    .out_i       (s1_out_q),
    .exact_i     (s1_exact_q),
    .vec_i       (s1_vec_q),
    .max_err_o   (bus.max_err),
    .worst_vec_o (bus.worst_vec),
    .err_count_o (bus.err_count),
    .sum_err_o   (bus.sum_err),
    .max_nxt_o   (max_nxt)
  );

  assign bus.dut_in = v_q;
  assign bus.busy   = (state_q == SWEEP)
                   || (state_q == DRAIN);
  assign bus.done   = (state_q == DONE);
  assign bus.pass   = pass_q;

endmodule
